// File: rtl/sram_controller.sv
// sram_controller: turns each 32-bit word load/store from the MEM stage into
// two timed 16-bit SRAM accesses (low half first). It stalls the pipeline via
// `pause` until the word transfer has completed.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024, // byte address of SRAM word 0
    parameter int          WAIT_CYCLES = 2         // cycles per half-word phase, 1..15
) (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active-low
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        pause,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    // Terminal count of the per-phase cycle counter.
    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        op_wr;      // latched operation: 1 = store, 0 = load
    logic [16:0] wa;         // latched SRAM word address
    logic [15:0] wdata_hi;   // upper store half, used in the HI phase
    logic [15:0] dq_out;     // half-word currently driven onto the bus
    logic [16:0] wa_next;
    logic        req;

    assign req = wr_en | rd_en;

    // Word offset from the SRAM base; addresses below the base wrap silently.
    assign wa_next = 17'((address - BASE_ADDR) >> 2);

    // Combinational so the stall is visible in the request cycle itself; it
    // drops in DONE so the pipeline advances on the edge ending DONE.
    assign pause = req & (state != DONE) & rst;

    // The bus is driven only while a write strobe is active.
    assign SRAM_DQ = SRAM_WE_N ? 16'hzzzz : dq_out;

    // Transfer sequencer: state, counter, latched request and registered SRAM strobes.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // right-hand side below sees the pre-edge register values.
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_wr     <= 1'b0;
            wa        <= 17'd0;
            wdata_hi  <= 16'd0;
            dq_out    <= 16'd0;
            read_data <= 32'd0;
            SRAM_ADDR <= 18'd0;
            SRAM_CE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // Store wins when both requests are raised together.
                        op_wr     <= wr_en;
                        wa        <= wa_next;
                        wdata_hi  <= write_data[31:16];
                        dq_out    <= write_data[15:0];
                        cnt       <= 4'd0;
                        state     <= LO;
                        SRAM_ADDR <= {wa_next, 1'b0};
                        SRAM_CE_N <= 1'b0;
                        SRAM_UB_N <= 1'b0;
                        SRAM_LB_N <= 1'b0;
                        SRAM_WE_N <= ~wr_en;
                        SRAM_OE_N <= wr_en;
                    end
                end
                LO: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= 4'd0;
                        state     <= HI;
                        SRAM_ADDR <= {wa, 1'b1};
                        dq_out    <= wdata_hi;
                        if (!op_wr) begin
                            read_data[15:0] <= SRAM_DQ;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HI: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= 4'd0;
                        state     <= DONE;
                        SRAM_CE_N <= 1'b1;
                        SRAM_WE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        SRAM_UB_N <= 1'b1;
                        SRAM_LB_N <= 1'b1;
                        if (!op_wr) begin
                            read_data[31:16] <= SRAM_DQ;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed bench for sram_controller. Two instances share
// the request inputs (gated by dut_sel): one with WAIT_CYCLES=2, one with
// WAIT_CYCLES=1. Each has its own behavioural 256K x 16 SRAM.
module tb_sram_controller;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        dut_sel;   // 0 = W=2 instance, 1 = W=1 instance

    // W=2 instance signals
    logic        wr_en0, rd_en0, pause0, ub_n0, lb_n0, we_n0, ce_n0, oe_n0;
    logic [31:0] read_data0;
    logic [17:0] sram_addr0;
    wire  [15:0] dq0;
    logic [15:0] mem0 [0:262143];

    // W=1 instance signals
    logic        wr_en1, rd_en1, pause1, ub_n1, lb_n1, we_n1, ce_n1, oe_n1;
    logic [31:0] read_data1;
    logic [17:0] sram_addr1;
    wire  [15:0] dq1;
    logic [15:0] mem1 [0:262143];

    logic        pause_s;
    logic [31:0] read_data_s;

    int checks;
    int errors;
    int we_pulses0;
    logic [17:0] addr_log [$];

    assign wr_en0 = wr_en & ~dut_sel;
    assign rd_en0 = rd_en & ~dut_sel;
    assign wr_en1 = wr_en & dut_sel;
    assign rd_en1 = rd_en & dut_sel;
    assign pause_s     = dut_sel ? pause1 : pause0;
    assign read_data_s = dut_sel ? read_data1 : read_data0;

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en0),
        .rd_en      (rd_en0),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data0),
        .pause      (pause0),
        .SRAM_DQ    (dq0),
        .SRAM_ADDR  (sram_addr0),
        .SRAM_UB_N  (ub_n0),
        .SRAM_LB_N  (lb_n0),
        .SRAM_WE_N  (we_n0),
        .SRAM_CE_N  (ce_n0),
        .SRAM_OE_N  (oe_n0)
    );

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en1),
        .rd_en      (rd_en1),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data1),
        .pause      (pause1),
        .SRAM_DQ    (dq1),
        .SRAM_ADDR  (sram_addr1),
        .SRAM_UB_N  (ub_n1),
        .SRAM_LB_N  (lb_n1),
        .SRAM_WE_N  (we_n1),
        .SRAM_CE_N  (ce_n1),
        .SRAM_OE_N  (oe_n1)
    );

    // SRAM models: drive the bus on an enabled read, store on an enabled write.
    assign dq0 = (!ce_n0 && !oe_n0 && we_n0) ? mem0[sram_addr0] : 16'hzzzz;
    assign dq1 = (!ce_n1 && !oe_n1 && we_n1) ? mem1[sram_addr1] : 16'hzzzz;

    always @(posedge clk) begin
        if (!ce_n0 && !we_n0 && !ub_n0 && !lb_n0) mem0[sram_addr0] <= dq0;
        if (!ce_n1 && !we_n1 && !ub_n1 && !lb_n1) mem1[sram_addr1] <= dq1;
    end

    // Distinct consecutive SRAM addresses presented while the chip is enabled.
    always @(negedge clk) begin
        if (!ce_n0 && (addr_log.size() == 0 || addr_log[addr_log.size()-1] != sram_addr0))
            addr_log.push_back(sram_addr0);
    end

    always @(negedge we_n0) we_pulses0++;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one request just after a rising edge and follows it to its DONE
    // cycle. Returns with the request still applied, #1 after the edge that
    // ends DONE, so a following call starts back-to-back.
    task automatic run_op(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, output int hi_cycles,
                          output int done_cycle, output logic [31:0] rd_done);
        int   cycle;
        logic found;
        wr_en      = w;
        rd_en      = r;
        address    = a;
        write_data = d;
        cycle      = 0;
        found      = 1'b0;
        hi_cycles  = 0;
        done_cycle = -1;
        rd_done    = 32'h0;
        while (!found && cycle < 40) begin
            @(negedge clk);
            if (pause_s) begin
                hi_cycles++;
            end else begin
                found      = 1'b1;
                done_cycle = cycle;
                rd_done    = read_data_s;
            end
            @(posedge clk);
            #1;
            cycle++;
        end
        check("op_reached_done", 32'(found), 32'd1);
    endtask

    task automatic go_idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hi, dn, hi2, dn2, base, p0;
        logic [31:0] rdv;

        checks     = 0;
        errors     = 0;
        dut_sel    = 1'b0;
        rst        = 1'b0;
        wr_en      = 1'b1;   // a request during reset must not raise pause
        rd_en      = 1'b0;
        address    = 32'd1024;
        write_data = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_pause", 32'(pause0), 32'd0);
        check("reset_read_data", read_data0, 32'd0);
        check("reset_sram_addr", 32'(sram_addr0), 32'd0);
        check("reset_strobes", 32'({ce_n0, we_n0, oe_n0, ub_n0, lb_n0}), 32'h1F);
        wr_en = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;

        // Store/load round trip, W=2
        run_op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, hi, dn, rdv);
        check("rt_store_pause_cycles", 32'(hi), 32'd5);
        check("rt_store_done_cycle", 32'(dn), 32'd5);
        check("rt_mem_hw0", 32'(mem0[0]), 32'h0000BEEF);
        check("rt_mem_hw1", 32'(mem0[1]), 32'h0000DEAD);
        run_op(1'b0, 1'b1, 32'd1024, 32'h0, hi, dn, rdv);
        check("rt_load_done_cycle", 32'(dn), 32'd5);
        check("rt_load_read_data", rdv, 32'hDEADBEEF);
        go_idle();

        // Back-to-back stores
        base = addr_log.size();
        run_op(1'b1, 1'b0, 32'd1028, 32'h11112222, hi, dn, rdv);
        run_op(1'b1, 1'b0, 32'd1032, 32'h33334444, hi2, dn2, rdv);
        go_idle();
        check("b2b_total_cycles", 32'(dn + 1 + dn2 + 1), 32'd12);
        check("b2b_pause_high_cycles", 32'(hi + hi2), 32'd10);
        check("b2b_addr_count", 32'(addr_log.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < addr_log.size())
                check($sformatf("b2b_addr_%0d", i), 32'(addr_log[base+i]), 32'(2 + i));
        end
        check("b2b_mem_hw2", 32'(mem0[2]), 32'h00002222);
        check("b2b_mem_hw5", 32'(mem0[5]), 32'h00003333);

        // Wrap-around below the base address
        base = addr_log.size();
        run_op(1'b1, 1'b0, 32'd1020, 32'hCAFEF00D, hi, dn, rdv);
        go_idle();
        check("wrap_addr_count", 32'(addr_log.size() - base), 32'd2);
        if (base + 1 < addr_log.size()) begin
            check("wrap_addr_lo", 32'(addr_log[base]), 32'h3FFFE);
            check("wrap_addr_hi", 32'(addr_log[base+1]), 32'h3FFFF);
        end
        check("wrap_mem_lo", 32'(mem0[18'h3FFFE]), 32'h0000F00D);
        check("wrap_mem_hi", 32'(mem0[18'h3FFFF]), 32'h0000CAFE);

        // Simultaneous requests: store wins, read_data untouched
        p0 = we_pulses0;
        run_op(1'b1, 1'b1, 32'd1036, 32'h0A0B0C0D, hi, dn, rdv);
        go_idle();
        check("sim_read_data_kept", rdv, 32'hDEADBEEF);
        check("sim_we_pulses", 32'(we_pulses0 - p0), 32'd1);
        check("sim_mem_hw6", 32'(mem0[6]), 32'h00000C0D);
        check("sim_mem_hw7", 32'(mem0[7]), 32'h00000A0B);

        // Reset abort in the first HI cycle of a store
        run_op(1'b1, 1'b0, 32'd1040, 32'h5A5A5A5A, hi, dn, rdv);
        go_idle();
        wr_en      = 1'b1;
        address    = 32'd1040;
        write_data = 32'h77778888;
        repeat (3) @(posedge clk);   // IDLE->LO, LO, LO->HI
        #1;
        check("abort_in_hi_addr", 32'(sram_addr0), 32'd9);
        rst = 1'b0;
        #1;
        check("abort_strobes", 32'({ce_n0, we_n0, oe_n0, ub_n0, lb_n0}), 32'h1F);
        check("abort_pause", 32'(pause0), 32'd0);
        check("abort_sram_addr", 32'(sram_addr0), 32'd0);
        wr_en = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_mem_lo_written", 32'(mem0[8]), 32'h00008888);
        check("abort_mem_hi_kept", 32'(mem0[9]), 32'h00005A5A);
        run_op(1'b0, 1'b1, 32'd1040, 32'h0, hi, dn, rdv);
        go_idle();
        check("abort_then_load_done", 32'(dn), 32'd5);
        check("abort_then_load_data", rdv, 32'h5A5A8888);

        // W=1 round trip
        dut_sel = 1'b1;
        run_op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, hi, dn, rdv);
        check("w1_store_pause_cycles", 32'(hi), 32'd3);
        check("w1_store_done_cycle", 32'(dn), 32'd3);
        check("w1_mem_hw0", 32'(mem1[0]), 32'h0000BEEF);
        check("w1_mem_hw1", 32'(mem1[1]), 32'h0000DEAD);
        run_op(1'b0, 1'b1, 32'd1024, 32'h0, hi, dn, rdv);
        go_idle();
        check("w1_load_pause_cycles", 32'(hi), 32'd3);
        check("w1_load_done_cycle", 32'(dn), 32'd3);
        check("w1_load_read_data", rdv, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Sequencer between the MEM pipeline stage and the external 16-bit SRAM. It converts each 32-bit word load or store into two timed half-word SRAM accesses, low half first. It drives all SRAM control strobes and holds `pause` high so the whole pipeline stalls until the word transfer completes. It replaces direct MEM-stage access to the SRAM bus.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.
- `WAIT_CYCLES`, default 2: cycles each half-word phase is held. Legal range is 1..15.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `wr_en` input 1: store request from the MEM stage.
- `rd_en` input 1: load request from the MEM stage.
- `address` input 32: byte address (ALU result).
- `write_data` input 32: store data.
- `read_data` output 32: load data, registered.
- `pause` output 1: stall request to all pipeline stages.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` output 18: SRAM half-word address.
- `SRAM_UB_N`, `SRAM_LB_N` output 1: byte masks, active-low.
- `SRAM_WE_N`, `SRAM_CE_N`, `SRAM_OE_N` output 1: write enable, chip enable and output enable, all active-low.

## Operation
- The FSM has four states: IDLE, LO, HI, DONE. A cycle counter `cnt` (4 bits) runs inside LO and HI.
- **IDLE:**
  - If `wr_en|rd_en`, latch the request: op (write has priority when both are high), word address `wa = (address - BASE_ADDR) >> 2` truncated to 17 bits, and `write_data`.
  - Set `cnt=0` and go to LO.
  - With no request, stay in IDLE.
- **LO:**
  - `SRAM_ADDR = {wa,1'b0}`, `CE_N=0`, `UB_N=LB_N=0`.
  - Write: `WE_N=0`, `OE_N=1`, DQ driven with `wdata[15:0]`.
  - Read: `WE_N=1`, `OE_N=0`, DQ high-Z. On the last LO cycle, `read_data[15:0] <= SRAM_DQ`.
  - When `cnt==WAIT_CYCLES-1`: set `cnt=0` and go to HI. Otherwise increment `cnt`.
- **HI:**
  - Same as LO, but with `SRAM_ADDR = {wa,1'b1}` and data half `[31:16]`.
  - When `cnt==WAIT_CYCLES-1`, go to DONE.
- **DONE:** all strobes deasserted. The next state is IDLE unconditionally.
- **Pause:** `pause = (wr_en|rd_en) & (state != DONE) & rst`. It is combinational, so it is high in the request cycle itself.
- **Idle outputs:** outside LO/HI all strobes are high (`CE_N`, `WE_N`, `OE_N`, `UB_N`, `LB_N`), `SRAM_ADDR` holds its last value, and DQ is high-Z.
- **Request changes:** changes to the request inputs during LO/HI/DONE are ignored. The latched transaction always completes.
- **Address wrap:** the address arithmetic is modulo 2^17 words. Addresses below `BASE_ADDR` wrap. This is not flagged.
- **Read data:** `read_data` keeps its value until the next read overwrites it. Writes do not modify it.

## Timing
- **Reset:**
  - While `rst=0`: state=IDLE, `cnt=0`, `read_data=0`, `SRAM_ADDR=0`, all SRAM strobes =1, DQ high-Z, `pause=0`.
  - Reset asserted mid-transaction aborts it immediately. The SRAM may hold a half-written word.
- **Access latency:**
  - A request seen in IDLE at cycle 0 keeps `pause=1` for cycles 0..2·W.
  - DONE is cycle 2·W+1, where `pause=0`. The stage registers advance on the edge ending DONE.
  - Total access time is 2·W+2 cycles: 6 cycles for W=2, 4 cycles for W=1.
- **Read capture:** `read_data` is fully valid in the DONE cycle. The low half is valid from cycle W+1.
- **Back-to-back:**
  - A new request presented in the cycle after DONE starts in IDLE with no extra gap.
  - N consecutive memory instructions therefore take N·(2W+2) cycles.
- **Bus timing:** address, data and strobes change only on clock edges. DQ is driven only while `WE_N=0`.

## Test plan
- **Store/load round trip:** `wr_en`, address 1024, data 0xDEADBEEF, W=2. Required response:
  - `pause` high for cycles 0..4.
  - SRAM half-word 0 = 0xBEEF and half-word 1 = 0xDEAD.
  - A following `rd_en` at 1024 gives `read_data=0xDEADBEEF` in its DONE cycle (cycle 5).
- **Back-to-back stores:** stores to 1028 (0x11112222) and 1032 (0x33334444) in consecutive requests. Required response:
  - Total 12 cycles with `pause` low only in the two DONE cycles.
  - SRAM_ADDR sequence 2, 3, 4, 5.
- **Reset abort:** assert `rst=0` in the first HI cycle of a write. Required response:
  - Strobes go high asynchronously, `pause=0` and state IDLE.
  - Only the low half is written.
- **Simultaneous requests:** `wr_en=rd_en=1` at 1036 with data 0x0A0B0C0D. Required response: a write occurs (`WE_N` pulses) and `read_data` is unchanged.
- **Wrap-around:** address 1020 (below `BASE_ADDR`) with a write. Required response: `SRAM_ADDR` = 0x3FFFE then 0x3FFFF.
- **W=1:** run the round-trip scenario with `WAIT_CYCLES=1`. Required response: `pause` high for 3 cycles and DONE at cycle 3.
